orv32s_inst_align: RTL and testbench



---
 rtl/orv32s_inst_align.sv | 125 ++++++++++++
 tb/tb_orv32s_inst_align.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/orv32s_inst_align.sv
// RVC-aware instruction realigner: buffers fetch words as halfwords and hands
// decode one 16- or 32-bit instruction per cycle, tagged with PC and flags.
module orv32s_inst_align #(
    parameter int unsigned FETCH_W  = 32,
    parameter int unsigned BUF_HW   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [31:0]        redirect_pc_i,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [FETCH_W-1:0] fetch_data_i,
    input  logic               fetch_err_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_o,
    output logic [31:0]        inst_pc_o,
    output logic               inst_is_rvc_o,
    output logic               inst_is_zero_o,
    output logic               inst_err_o
);
    localparam int unsigned NHW   = FETCH_W / 16;
    localparam int unsigned PTR_W = $clog2(BUF_HW);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OFF_W = $clog2(NHW);

    logic [15:0]       r_data [BUF_HW];
    logic [BUF_HW-1:0] r_err;
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_pc;
    logic              r_halted;
    logic              r_drop_armed;

    logic [PTR_W-1:0]  w_rd1;
    logic [15:0]       w_hw0;
    logic [15:0]       w_hw1;
    logic              w_err0;
    logic              w_err1;
    logic              w_is_rvc;
    logic              w_single;
    logic              w_valid;
    logic              w_inst_err;
    logic              w_push;
    logic              w_pop;
    logic [OFF_W-1:0]  w_drop_off;
    logic [CNT_W-1:0]  w_push_n;
    logic [CNT_W-1:0]  w_pop_n;
    logic              w_unused;

    assign w_unused = redirect_pc_i[0];

    // Head view: the instruction (if any) that starts at the read pointer.
    assign w_rd1    = r_rd + PTR_W'(1);
    assign w_hw0    = r_data[r_rd];
    assign w_hw1    = r_data[w_rd1];
    assign w_err0   = r_err[r_rd];
    assign w_err1   = r_err[w_rd1];
    assign w_is_rvc = (w_hw0[1:0] != 2'b11);
    // An errored first halfword is emitted alone so the fault surfaces at once.
    assign w_single = w_is_rvc || w_err0;
    assign w_valid  = !r_halted &&
                      (((r_cnt >= CNT_W'(1)) && w_single) || (r_cnt >= CNT_W'(2)));
    assign w_inst_err = w_err0 || (!w_is_rvc && w_err1);
    assign w_pop_n  = w_single ? CNT_W'(1) : CNT_W'(2);

    assign fetch_ready_o = (r_cnt <= CNT_W'(BUF_HW - NHW));
    assign w_drop_off    = r_drop_armed ? r_pc[OFF_W:1] : '0;
    assign w_push_n      = CNT_W'(NHW) - CNT_W'(w_drop_off);
    assign w_push        = fetch_valid_i && fetch_ready_o && !flush_i;
    assign w_pop         = w_valid && inst_ready_i && !flush_i;

    assign inst_valid_o   = w_valid;
    assign inst_o         = w_is_rvc ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
    assign inst_pc_o      = r_pc;
    assign inst_is_rvc_o  = w_is_rvc;
    assign inst_is_zero_o = w_is_rvc && (w_hw0 == 16'h0000);
    assign inst_err_o     = w_inst_err;

    // Halfword storage; leading halfwords below the start PC are skipped once.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int j = 0; j < int'(NHW); j++) begin
                if (j >= int'(w_drop_off)) begin
                    r_data[r_wr + PTR_W'(j - int'(w_drop_off))] <= fetch_data_i[16*j +: 16];
                    r_err[r_wr + PTR_W'(j - int'(w_drop_off))]  <= fetch_err_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_cnt        <= '0;
            r_pc         <= RESET_PC;
            r_halted     <= 1'b0;
            r_drop_armed <= 1'b1;
        end else if (flush_i) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_cnt        <= '0;
            r_pc         <= {redirect_pc_i[31:1], 1'b0};
            r_halted     <= 1'b0;
            r_drop_armed <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr         <= r_wr + w_push_n[PTR_W-1:0];
                r_drop_armed <= 1'b0;
            end
            if (w_pop) begin
                r_rd <= r_rd + w_pop_n[PTR_W-1:0];
                r_pc <= r_pc + (w_single ? 32'd2 : 32'd4);
                if (w_inst_err) begin
                    r_halted <= 1'b1;
                end
            end
            r_cnt <= r_cnt + (w_push ? w_push_n : '0) - (w_pop ? w_pop_n : '0);
        end
    end
endmodule

// File: tb/tb_orv32s_inst_align.sv
// Bench for orv32s_inst_align: directed cases on 32- and 64-bit fetch variants
// plus randomized traffic against a halfword-queue reference model.
module tb_orv32s_inst_align;
    logic clk;
    logic rst;

    logic        a_flush, a_fv, a_ferr, a_rdy;
    logic [31:0] a_rpc, a_fdata;
    logic        a_frdy, a_vld, a_rvc, a_zero, a_err;
    logic [31:0] a_inst, a_pc;

    logic        b_flush, b_fv, b_ferr, b_rdy;
    logic [31:0] b_rpc;
    logic [63:0] b_fdata;
    logic        b_frdy, b_vld, b_rvc, b_zero, b_err;
    logic [31:0] b_inst, b_pc;

    orv32s_inst_align #(.FETCH_W(32), .BUF_HW(8), .RESET_PC(32'h0)) u_dut32 (
        .clk(clk), .rst(rst), .flush_i(a_flush), .redirect_pc_i(a_rpc),
        .fetch_valid_i(a_fv), .fetch_ready_o(a_frdy), .fetch_data_i(a_fdata),
        .fetch_err_i(a_ferr), .inst_valid_o(a_vld), .inst_ready_i(a_rdy),
        .inst_o(a_inst), .inst_pc_o(a_pc), .inst_is_rvc_o(a_rvc),
        .inst_is_zero_o(a_zero), .inst_err_o(a_err)
    );

    orv32s_inst_align #(.FETCH_W(64), .BUF_HW(8), .RESET_PC(32'h0)) u_dut64 (
        .clk(clk), .rst(rst), .flush_i(b_flush), .redirect_pc_i(b_rpc),
        .fetch_valid_i(b_fv), .fetch_ready_o(b_frdy), .fetch_data_i(b_fdata),
        .fetch_err_i(b_ferr), .inst_valid_o(b_vld), .inst_ready_i(b_rdy),
        .inst_o(b_inst), .inst_pc_o(b_pc), .inst_is_rvc_o(b_rvc),
        .inst_is_zero_o(b_zero), .inst_err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of {err, halfword} with capacity 8.
    logic [16:0] mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_drop;

    task automatic m_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_halt = 0;
        m_drop = 1;
    endtask

    task automatic cycle32();
        logic e_vld, e_rdy, e_rvc, e_one, e_err, do_pop, do_push;
        logic [31:0] e_inst;
        int pop_n, off;
        @(negedge clk);
        e_rdy = ((8 - mq.size()) >= 2);
        e_vld = 0; e_rvc = 0; e_one = 0; e_err = 0; e_inst = 0; pop_n = 0;
        if (mq.size() >= 1) begin
            e_rvc = (mq[0][1:0] != 2'b11);
            e_one = e_rvc || mq[0][16];
            e_vld = !m_halt && (e_one || mq.size() >= 2);
            pop_n = e_one ? 1 : 2;
            if (e_vld) begin
                if (e_rvc) begin
                    e_err  = mq[0][16];
                    e_inst = {16'h0, mq[0][15:0]};
                end else if (mq.size() >= 2) begin
                    e_err  = mq[0][16] || mq[1][16];
                    e_inst = {mq[1][15:0], mq[0][15:0]};
                end else begin
                    e_err  = 1'b1;
                end
            end
        end
        check_eq("m_vld", a_vld, e_vld);
        check_eq("m_frdy", a_frdy, e_rdy);
        if (e_vld) begin
            check_eq("m_pc", a_pc, m_pc);
            check_eq("m_rvc", a_rvc, e_rvc);
            check_eq("m_err", a_err, e_err);
            check_eq("m_zero", a_zero, e_rvc && (mq[0][15:0] == 16'h0));
            if (!(mq[0][16] && !e_rvc)) check_eq("m_inst", a_inst, e_inst);
        end
        do_pop  = e_vld && a_rdy && !a_flush;
        do_push = a_fv && e_rdy && !a_flush;
        off     = m_drop ? int'(m_pc[1]) : 0;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (a_flush) begin
            mq.delete();
            m_pc   = {a_rpc[31:1], 1'b0};
            m_halt = 0;
            m_drop = 1;
        end else begin
            if (do_pop) begin
                for (int k = 0; k < pop_n; k++) void'(mq.pop_front());
                m_pc = m_pc + 32'(2 * pop_n);
                if (e_err) m_halt = 1;
            end
            if (do_push) begin
                for (int j = off; j < 2; j++) mq.push_back({a_ferr, a_fdata[16*j +: 16]});
                m_drop = 0;
            end
        end
        #1;
    endtask

    task automatic drv(input logic fl, input logic [31:0] rpc, input logic fv,
                       input logic [31:0] fd, input logic fe, input logic rd);
        a_flush = fl; a_rpc = rpc; a_fv = fv; a_fdata = fd; a_ferr = fe; a_rdy = rd;
        cycle32();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [31:0] rnd_d;

    initial begin
        rst = 1;
        a_flush = 0; a_rpc = 0; a_fv = 0; a_fdata = 0; a_ferr = 0; a_rdy = 0;
        b_flush = 0; b_rpc = 0; b_fv = 0; b_fdata = 0; b_ferr = 0; b_rdy = 0;
        m_reset();
        tick(); tick();
        rst = 0;

        check_eq("rst32_vld", a_vld, 0);
        check_eq("rst32_frdy", a_frdy, 1);
        check_eq("rst64_vld", b_vld, 0);
        check_eq("rst64_frdy", b_frdy, 1);

        // 64-bit variant: fill to full, then drain and watch ready return.
        b_fv = 1; b_fdata = 64'h0001_0001_0001_0001; tick();
        check_eq("f64_vld", b_vld, 1);
        check_eq("f64_rdy_half", b_frdy, 1);
        b_fdata = 64'h0005_0005_0005_0005; tick();
        check_eq("f64_full", b_frdy, 0);
        tick();
        check_eq("f64_hold", b_frdy, 0);
        b_fv = 0; b_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("f64_drain_rdy", b_frdy, (i == 3));
            check_eq("f64_drain_pc", b_pc, 32'(2 * (i + 1)));
        end
        check_eq("f64_inst2", b_inst, 32'h0000_0005);
        for (int i = 0; i < 4; i++) tick();
        check_eq("f64_empty", b_vld, 0);
        b_rdy = 0; b_flush = 1; b_rpc = 32'h6; tick();
        b_flush = 0;
        check_eq("d64_vld", b_vld, 0);
        b_fv = 1; b_fdata = 64'h0004_0003_0002_0001; tick();
        b_fv = 0;
        check_eq("d64_inst", b_inst, 32'h0000_0004);
        check_eq("d64_pc", b_pc, 32'h6);
        b_rdy = 1; tick();
        check_eq("d64_drained", b_vld, 0);
        b_rdy = 0;

        // 32-bit variant: two RVC in one word.
        drv(0, 0, 1, 32'h0001_4501, 0, 0);
        check_eq("t1_inst0", a_inst, 32'h0000_4501);
        check_eq("t1_pc0", a_pc, 32'h0);
        check_eq("t1_rvc0", a_rvc, 1);
        drv(0, 0, 0, 0, 0, 1);
        check_eq("t1_inst1", a_inst, 32'h0000_0001);
        check_eq("t1_pc1", a_pc, 32'h2);
        drv(0, 0, 0, 0, 0, 1);
        check_eq("t1_empty", a_vld, 0);

        // Straddling 32-bit instruction, then a zero RVC.
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 32'h0513_0001, 0, 0);
        check_eq("t2_inst0", a_inst, 32'h0000_0001);
        drv(0, 0, 1, 32'h0000_0000, 0, 1);
        check_eq("t2_inst1", a_inst, 32'h0000_0513);
        check_eq("t2_pc1", a_pc, 32'h2);
        check_eq("t2_rvc1", a_rvc, 0);
        drv(0, 0, 0, 0, 0, 1);
        check_eq("t2_pc2", a_pc, 32'h6);
        check_eq("t2_zero2", a_zero, 1);

        // Straddle waits for its upper half; error upper half halts.
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 32'h0513_0001, 0, 1);
        drv(0, 0, 0, 0, 0, 1);
        check_eq("t5_wait", a_vld, 0);
        drv(0, 0, 1, 32'h0000_0000, 1, 0);
        check_eq("t5_errvld", a_vld, 1);
        check_eq("t5_err", a_err, 1);
        check_eq("t5_errpc", a_pc, 32'h2);
        drv(0, 0, 0, 0, 0, 1);
        check_eq("t5_halt", a_vld, 0);
        drv(0, 0, 1, 32'h0001_4501, 0, 1);
        check_eq("t5_halt2", a_vld, 0);
        drv(1, 32'h40, 0, 0, 0, 1);
        check_eq("t5_flush_rdy", a_frdy, 1);
        drv(0, 0, 1, 32'h0001_4501, 0, 0);
        check_eq("t5_resume", a_inst, 32'h0000_4501);
        check_eq("t5_resume_pc", a_pc, 32'h40);

        // Redirect into the upper halfword drops the lower one.
        drv(1, 32'h0000_0103, 0, 0, 0, 0);
        check_eq("t3_vld", a_vld, 0);
        drv(0, 0, 1, 32'h4505_FFFF, 0, 0);
        check_eq("t3_inst", a_inst, 32'h0000_4505);
        check_eq("t3_pc", a_pc, 32'h102);

        // Flush beats same-cycle push and pop.
        drv(1, 32'h200, 1, 32'h0001_0001, 0, 1);
        check_eq("t6_vld", a_vld, 0);
        check_eq("t6_frdy", a_frdy, 1);
        drv(0, 0, 1, 32'h0001_4501, 0, 0);
        check_eq("t6_inst", a_inst, 32'h0000_4501);
        check_eq("t6_pc", a_pc, 32'h200);

        for (int i = 0; i < 1500; i++) begin
            rnd_d = $urandom;
            if ($urandom_range(0, 7) == 0) rnd_d[15:0] = 16'h0;
            if ($urandom_range(0, 5) == 0) rnd_d[17:16] = 2'b11;
            rst = ($urandom_range(0, 299) == 0);
            drv(($urandom_range(0, 24) == 0), $urandom, ($urandom_range(0, 9) < 6),
                rnd_d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7));
        end
        rst = 0;
        drv(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
